// File: rtl/z80_exec_sequencer.sv
// Post-download execute sequencer: captures the start address, waits for the
// download to settle, stalls the Z80 at an M1 boundary and loads PC/SP via DIR.
module z80_exec_sequencer #(
   parameter logic [15:0] SP_ADDR       = 16'h4200,
   parameter int unsigned SETTLE_CYCLES = 64,
   parameter int unsigned SET_CYCLES    = 4,
   parameter int unsigned SYNC_TIMEOUT  = 65535
) (
   input  logic         i_clk_sys,
   input  logic         i_reset,
   input  logic         i_load_active,
   input  logic         i_exec_valid,
   input  logic [15:0]  i_exec_addr,
   input  logic         i_exec_enable,
   input  logic         i_cpu_m1_n,
   output logic         o_cpu_wait,
   output logic [211:0] o_dir_out,
   output logic         o_dir_set,
   output logic         o_busy,
   output logic         o_exec_done
);

   localparam int unsigned CNT_W     = 16;
   localparam int unsigned DIR_W     = 212;
   localparam int unsigned DIR_PAD_W = DIR_W - 80;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SET_LAST    = CNT_W'(SET_CYCLES - 1);
   localparam logic [CNT_W-1:0] SYNC_LAST   = CNT_W'(SYNC_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOADING,
      S_SETTLE,
      S_SYNC,
      S_HOLD,
      S_SET,
      S_RELEASE
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             r_armed;
   logic             w_armed_next;
   logic [15:0]      r_addr;
   logic [15:0]      w_addr_next;
   logic             r_m1_n_q;
   logic             w_m1_fall;
   logic             w_capture;

   // PC field tracks the captured address; everything else is a fixed reset image
   assign o_dir_out = {{DIR_PAD_W{1'b0}}, r_addr, SP_ADDR, 16'h0000, 8'h01, 8'h01, 16'h0001};

   assign w_m1_fall = r_m1_n_q & ~i_cpu_m1_n;
   assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

   // A strobe in the IDLE cycle that starts a download belongs to that download
   assign w_capture = i_exec_valid &&
                      ((r_state == S_IDLE && i_load_active) ||
                       r_state == S_LOADING || r_state == S_SETTLE);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_armed_next = r_armed;
      w_addr_next  = r_addr;

      if (w_capture) begin
         w_addr_next  = i_exec_addr;
         w_armed_next = 1'b1;
      end

      case (r_state)
         S_IDLE: begin
            if (i_load_active) w_state_next = S_LOADING;
         end
         S_LOADING: begin
            if (!i_load_active) begin
               if (w_armed_next && i_exec_enable) begin
                  w_state_next = S_SETTLE;
                  w_cnt_next   = '0;
               end else begin
                  w_state_next = S_IDLE;
                  w_armed_next = 1'b0;
               end
            end
         end
         S_SETTLE: begin
            if (i_load_active) begin
               w_state_next = S_LOADING;
            end else if (r_cnt == SETTLE_LAST) begin
               w_state_next = S_SYNC;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end
         S_SYNC: begin
            if (w_m1_fall || r_cnt == SYNC_LAST) begin
               w_state_next = S_HOLD;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end
         S_HOLD: begin
            w_state_next = S_SET;
            w_cnt_next   = '0;
         end
         S_SET: begin
            if (r_cnt == SET_LAST) begin
               w_state_next = S_RELEASE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = w_cnt_inc;
            end
         end
         S_RELEASE: begin
            w_state_next = S_IDLE;
            w_armed_next = 1'b0;
         end
         default: begin
            w_state_next = S_IDLE;
            w_armed_next = 1'b0;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they line up with the state register
   always_ff @(posedge i_clk_sys) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_armed     <= 1'b0;
         r_addr      <= '0;
         r_m1_n_q    <= 1'b1;
         o_cpu_wait  <= 1'b0;
         o_dir_set   <= 1'b0;
         o_busy      <= 1'b0;
         o_exec_done <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         r_armed     <= w_armed_next;
         r_addr      <= w_addr_next;
         r_m1_n_q    <= i_cpu_m1_n;
         o_cpu_wait  <= (w_state_next == S_HOLD) || (w_state_next == S_SET);
         o_dir_set   <= (w_state_next == S_SET);
         o_busy      <= (w_state_next != S_IDLE);
         o_exec_done <= (w_state_next == S_RELEASE);
      end
   end

endmodule
